// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command front-end.
// Contents: default data width, 3-bit ALU opcodes, sequencer FSM state type.
package alu_pkg;

    localparam int unsigned ALU_W = 32;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_PASS = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_DIV  = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO holding packed ALU commands.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_push, i_wdata      write request and data (ignored when full)
//   i_pop                read request (ignored when empty)
//   o_rdata              head entry, valid whenever o_empty is 0
//   o_full, o_empty      occupancy flags
//   o_count              number of stored entries, 0..DEPTH
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_wdata,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CNTW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNTW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + CNTW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNTW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands and issues them one at a time.
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready            command handshake (ready = FIFO not full)
//   i_cmd_a, i_cmd_b, i_cmd_op         command operands and opcode
//   o_alu_a, o_alu_b, o_alu_op, o_alu_en   registered ALU drive
//   i_alu_res, i_alu_ack               ALU result and completion
//   o_rsp_valid/i_rsp_ready            response handshake
//   o_rsp_res, o_rsp_op, o_rsp_err     response payload (res=0 on error)
// Divide-by-zero is answered without touching the ALU; a missing ack aborts
// the command after TIMEOUT enabled cycles.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned W       = ALU_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [W-1:0] i_cmd_a,
    input  logic [W-1:0] i_cmd_b,
    input  logic [2:0]   i_cmd_op,
    output logic [W-1:0] o_alu_a,
    output logic [W-1:0] o_alu_b,
    output logic [2:0]   o_alu_op,
    output logic         o_alu_en,
    input  logic [W-1:0] i_alu_res,
    input  logic         i_alu_ack,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [W-1:0] o_rsp_res,
    output logic [2:0]   o_rsp_op,
    output logic         o_rsp_err
);

    localparam int unsigned FW   = 2 * W + 3;
    localparam int unsigned CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_alu_a, w_alu_a_nxt;
    logic [W-1:0]    r_alu_b, w_alu_b_nxt;
    logic [2:0]      r_alu_op, w_alu_op_nxt;
    logic            r_alu_en, w_alu_en_nxt;
    logic [W-1:0]    r_rsp_res, w_rsp_res_nxt;
    logic [2:0]      r_rsp_op, w_rsp_op_nxt;
    logic            r_rsp_err, w_rsp_err_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;

    logic            w_push;
    logic            w_pop;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CNTW-1:0] w_unused_fifo_count;
    logic [FW-1:0]   w_head;
    logic [2:0]      w_head_op;
    logic [W-1:0]    w_head_a;
    logic [W-1:0]    w_head_b;

    // Ready comes from registered occupancy only: no push while full, even on a pop.
    assign o_cmd_ready = !w_fifo_full;
    assign w_push      = i_cmd_valid && !w_fifo_full;

    assign w_head_op = w_head[FW-1 -: 3];
    assign w_head_a  = w_head[2*W-1 -: W];
    assign w_head_b  = w_head[W-1:0];

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata ({i_cmd_op, i_cmd_a, i_cmd_b}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_unused_fifo_count)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_alu_a_nxt   = r_alu_a;
        w_alu_b_nxt   = r_alu_b;
        w_alu_op_nxt  = r_alu_op;
        w_alu_en_nxt  = r_alu_en;
        w_rsp_res_nxt = r_rsp_res;
        w_rsp_op_nxt  = r_rsp_op;
        w_rsp_err_nxt = r_rsp_err;
        w_cnt_nxt     = r_cnt;
        w_pop         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (w_head_op == OP_DIV && w_head_b == '0) begin
                        w_rsp_op_nxt  = w_head_op;
                        w_rsp_res_nxt = '0;
                        w_rsp_err_nxt = 1'b1;
                        w_state_nxt   = StResp;
                    end else begin
                        w_alu_a_nxt  = w_head_a;
                        w_alu_b_nxt  = w_head_b;
                        w_alu_op_nxt = w_head_op;
                        w_alu_en_nxt = 1'b1;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = StBusy;
                    end
                end
            end
            StBusy: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (i_alu_ack) begin
                    w_rsp_res_nxt = i_alu_res;
                    w_rsp_op_nxt  = r_alu_op;
                    w_rsp_err_nxt = 1'b0;
                    w_alu_en_nxt  = 1'b0;
                    w_state_nxt   = StResp;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_rsp_res_nxt = '0;
                    w_rsp_op_nxt  = r_alu_op;
                    w_rsp_err_nxt = 1'b1;
                    w_alu_en_nxt  = 1'b0;
                    w_state_nxt   = StResp;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            StResp: begin
                if (i_rsp_ready) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_alu_en  <= 1'b0;
            r_rsp_res <= '0;
            r_rsp_op  <= '0;
            r_rsp_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_alu_a   <= w_alu_a_nxt;
            r_alu_b   <= w_alu_b_nxt;
            r_alu_op  <= w_alu_op_nxt;
            r_alu_en  <= w_alu_en_nxt;
            r_rsp_res <= w_rsp_res_nxt;
            r_rsp_op  <= w_rsp_op_nxt;
            r_rsp_err <= w_rsp_err_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_op    = r_alu_op;
    assign o_alu_en    = r_alu_en;
    assign o_rsp_valid = (r_state == StResp);
    assign o_rsp_res   = r_rsp_res;
    assign o_rsp_op    = r_rsp_op;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed self-checking bench for alu_cmd_sequencer.
// Includes a behavioural ALU with programmable ack delay or no ack at all.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_en;
    logic [31:0] alu_res;
    logic        alu_ack;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic [2:0]  rsp_op;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    int ack_delay = 0;
    bit never_ack = 1'b0;
    int wait_cnt  = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .W       (32),
        .DEPTH   (4),
        .TIMEOUT (15)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_a     (cmd_a),
        .i_cmd_b     (cmd_b),
        .i_cmd_op    (cmd_op),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .o_alu_en    (alu_en),
        .i_alu_res   (alu_res),
        .i_alu_ack   (alu_ack),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_res   (rsp_res),
        .o_rsp_op    (rsp_op),
        .o_rsp_err   (rsp_err)
    );

    // Behavioural ALU: ack after ack_delay extra enabled cycles.
    assign alu_ack = alu_en && !never_ack && (wait_cnt == ack_delay);

    always @(posedge clk) begin
        if (!alu_en || alu_ack) wait_cnt <= 0;
        else                    wait_cnt <= wait_cnt + 1;
    end

    always_comb begin
        alu_res = 32'd0;
        case (alu_op)
            3'b000: alu_res = alu_a + alu_b;
            3'b001: alu_res = alu_a - alu_b;
            3'b010: alu_res = alu_a + 32'd1;
            3'b011: alu_res = alu_a - 32'd1;
            3'b100: alu_res = alu_a;
            3'b101: alu_res = ~alu_a;
            3'b110: alu_res = (alu_b != 0) ? alu_a / alu_b : 32'd0;
            3'b111: alu_res = alu_a & alu_b;
            default: alu_res = 32'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (cmd_ready !== 1'b1 || alu_en !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b en=%b valid=%b want 1 0 0", cmd_ready, alu_en, rsp_valid);
        end
        n_tests++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_alu: a=%0h b=%0h op=%0h want 0 0 0", alu_a, alu_b, alu_op);
        end
        n_tests++;
        if (rsp_res !== 32'd0 || rsp_op !== 3'd0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp: res=%0h op=%0h err=%b want 0 0 0", rsp_res, rsp_op, rsp_err);
        end
        repeat (2) tick();
        #3 rst_n = 1'b1;
        tick();
        n_tests++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b valid=%b want 1 0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_busy();
        bit saw = 1'b0;
        never_ack = 1'b1;
        push(32'd5, 32'd3, 3'b000);
        push(32'd6, 32'd1, 3'b000);
        n_tests++;
        if (alu_en !== 1'b1 || alu_a !== 32'd5) begin
            n_fail++;
            $display("FAIL midrst_busy: en=%b a=%0d want 1 5", alu_en, alu_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (alu_en !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_a !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_async: en=%b valid=%b ready=%b a=%0d want 0 0 1 0",
                     alu_en, rsp_valid, cmd_ready, alu_a);
        end
        #3 rst_n = 1'b1;
        never_ack = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rsp_valid || alu_en) saw = 1'b1;
        end
        n_tests++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet: activity=%b want 0", saw);
        end
    endtask

    task automatic test_single_add();
        push(32'd5, 32'd3, 3'b000);
        n_tests++;
        if (alu_en !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_n0: en=%b valid=%b want 0 0", alu_en, rsp_valid);
        end
        tick();
        n_tests++;
        if (alu_en !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 3'b000
            || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_issue: en=%b a=%0d b=%0d op=%0d valid=%b want 1 5 3 0 0",
                     alu_en, alu_a, alu_b, alu_op, rsp_valid);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_res !== 32'd8 || rsp_err !== 1'b0 || rsp_op !== 3'b000
            || alu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL add_rsp: valid=%b res=%0d err=%b op=%0d en=%b want 1 8 0 0 0",
                     rsp_valid, rsp_res, rsp_err, rsp_op, alu_en);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_done: valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_div0();
        push(32'd10, 32'd0, 3'b110);
        n_tests++;
        if (alu_en !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL div0_n0: en=%b valid=%b want 0 0", alu_en, rsp_valid);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_res !== 32'd0 || rsp_op !== 3'b110 || rsp_err !== 1'b1
            || alu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL div0_rsp: valid=%b res=%0d op=%0d err=%b en=%b want 1 0 6 1 0",
                     rsp_valid, rsp_res, rsp_op, rsp_err, alu_en);
        end
        tick();
        n_tests++;
        if (alu_en !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL div0_after: en=%b valid=%b want 0 0", alu_en, rsp_valid);
        end
    endtask

    task automatic test_fill();
        int          got   = 0;
        bit          extra = 1'b0;
        logic [31:0] exp;
        rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(32'(i), 32'd0, 3'b010);
        n_tests++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_res !== 32'd2) begin
            n_fail++;
            $display("FAIL fill_full: ready=%b valid=%b res=%0d want 0 1 2",
                     cmd_ready, rsp_valid, rsp_res);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 100 && got < 5; c++) begin
            if (rsp_valid) begin
                exp = 32'(got + 2);
                n_tests++;
                if (rsp_res !== exp || rsp_err !== 1'b0 || rsp_op !== 3'b010) begin
                    n_fail++;
                    $display("FAIL fill_order%0d: res=%0d err=%b op=%0d want %0d 0 2",
                             got, rsp_res, rsp_err, rsp_op, exp);
                end
                got++;
            end
            tick();
        end
        n_tests++;
        if (got != 5) begin
            n_fail++;
            $display("FAIL fill_count: got %0d responses want 5", got);
        end
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid) extra = 1'b1;
            tick();
        end
        n_tests++;
        if (extra !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_drain: extra=%b ready=%b want 0 1", extra, cmd_ready);
        end
    endtask

    task automatic test_timeout();
        int hi   = 0;
        bit seen = 1'b0;
        rsp_ready = 1'b1;
        never_ack = 1'b1;
        push(32'd7, 32'd2, 3'b001);
        push(32'd42, 32'd0, 3'b100);
        while (alu_en && hi < 40) begin
            hi++;
            tick();
        end
        n_tests++;
        if (hi != 15) begin
            n_fail++;
            $display("FAIL tmo_len: en cycles=%0d want 15", hi);
        end
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_res !== 32'd0 || rsp_op !== 3'b001) begin
            n_fail++;
            $display("FAIL tmo_rsp: valid=%b err=%b res=%0d op=%0d want 1 1 0 1",
                     rsp_valid, rsp_err, rsp_res, rsp_op);
        end
        never_ack = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b1 || rsp_res !== 32'd42 || rsp_err !== 1'b0 || rsp_op !== 3'b100) begin
            n_fail++;
            $display("FAIL tmo_next: seen=%b res=%0d err=%b op=%0d want 1 42 0 4",
                     seen, rsp_res, rsp_err, rsp_op);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat = 0;
        int en_cycles = 0;
        ack_delay = 3;
        rsp_ready = 1'b0;
        push(32'h0000_F0F0, 32'h0000_FF00, 3'b111);
        while (!rsp_valid && lat < 20) begin
            if (alu_en) en_cycles++;
            tick();
            lat++;
        end
        n_tests++;
        if (lat != 5 || en_cycles != 4) begin
            n_fail++;
            $display("FAIL bp_latency: lat=%0d en=%0d want 5 4", lat, en_cycles);
        end
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_res !== 32'h0000_F000 || rsp_op !== 3'b111
                || rsp_err !== 1'b0 || alu_en !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b res=%0h op=%0d err=%b en=%b want 1 f000 7 0 0",
                         c, rsp_valid, rsp_res, rsp_op, rsp_err, alu_en);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b want 0", rsp_valid);
        end
        ack_delay = 0;
    endtask

    task automatic test_back_to_back();
        int          n = 0;
        int          rcyc [8];
        logic [31:0] rres [8];
        int          cyc;
        rsp_ready = 1'b1;
        push(32'd10, 32'd0, 3'b011);
        push(32'd0, 32'd0, 3'b101);
        push(32'd100, 32'd23, 3'b000);
        cyc = 3;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid && n < 8) begin
                rcyc[n] = cyc;
                rres[n] = rsp_res;
                n++;
            end
            tick();
            cyc++;
        end
        n_tests++;
        if (n != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d responses want 3", n);
        end else begin
            n_tests++;
            if (rcyc[0] != 3 || rcyc[1] != 6 || rcyc[2] != 9) begin
                n_fail++;
                $display("FAIL b2b_cycles: %0d %0d %0d want 3 6 9", rcyc[0], rcyc[1], rcyc[2]);
            end
            n_tests++;
            if (rres[0] !== 32'd9 || rres[1] !== 32'hFFFF_FFFF || rres[2] !== 32'd123) begin
                n_fail++;
                $display("FAIL b2b_data: %0h %0h %0h want 9 ffffffff 7b", rres[0], rres[1], rres[2]);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = 32'd0;
        cmd_b     = 32'd0;
        cmd_op    = 3'd0;
        rsp_ready = 1'b1;
        test_reset();
        test_reset_mid_busy();
        test_single_add();
        test_div0();
        test_fill();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
